// File: rtl/cacheline_arbiter_pkg.sv
// Shared cache/arbiter types for the memory-side slice of the RV32I core.
// Imported by the cacheline arbiter and its helpers.
package cacheline_arbiter_pkg;

    localparam int LINE_OFF_W = 5;

    typedef enum logic [1:0] {
        CACHE_OP_NONE,
        CACHE_OP_READ,
        CACHE_OP_WRITE
    } cache_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one physical-memory cacheline port between icache and dcache.
// Round-robin on ties; every transaction passes through IDLE.
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants,
    output logic [CNT_W-1:0]  conflict_cycles
);

    arb_state_t state;
    arb_src_t   last_srv;

    logic i_pend;
    logic d_pend;
    logic i_done;
    logic d_done;
    logic conflict;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;
    assign i_done = (state == SERVE_I) && pmem_resp;
    assign d_done = (state == SERVE_D) && pmem_resp;

    assign conflict = ((state == SERVE_I) && d_pend)
                   || ((state == SERVE_D) && i_pend)
                   || ((state == IDLE) && i_pend && d_pend);

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_srv <= SRC_D;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_pend && d_pend) begin
                        state <= (last_srv == SRC_D) ? SERVE_I : SERVE_D;
                    end else if (i_pend) begin
                        state <= SERVE_I;
                    end else if (d_pend) begin
                        state <= SERVE_D;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state    <= IDLE;
                        last_srv <= SRC_I;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state    <= IDLE;
                        last_srv <= SRC_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Requests are a pure decode of state so reset drops them at once.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        unique case (state)
            SERVE_I: begin
                pmem_read = 1'b1;
                pmem_addr = i_addr;
                i_resp    = pmem_resp;
            end
            SERVE_D: begin
                pmem_read  = d_read;
                pmem_write = d_write;
                pmem_addr  = d_addr;
                pmem_wdata = d_wdata;
                d_resp     = pmem_resp;
            end
            default: begin
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_done),
        .count (i_grants)
    );

    sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_done),
        .count (d_grants)
    );

    sat_counter #(.CNT_W(CNT_W)) u_c_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (conflict),
        .count (conflict_cycles)
    );

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares the single physical-memory cacheline port between the instruction cache and the data cache of the pipelined RV32I core.
- Sits between the two caches and the cacheline adaptor.
- Serialises line fills and writebacks with a three-state FSM and round-robin tie-breaking.
- Keeps per-requester grant counters for performance monitoring.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, physical address width; line-aligned, low 5 bits zero.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_read  in  1  icache line-fill request.
- i_addr  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line-fill request.
- d_write  in  1  dcache writeback request.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache writeback data.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  downstream read request.
- pmem_write  out  1  downstream write request.
- pmem_addr  out  ADDR_W  downstream address.
- pmem_wdata  out  LINE_W  downstream write data.
- pmem_rdata  in  LINE_W  downstream read data.
- pmem_resp  in  1  downstream completion pulse.
- i_grants  out  CNT_W  completed icache transactions, saturating.
- d_grants  out  CNT_W  completed dcache transactions, saturating.
- conflict_cycles  out  CNT_W  cycles in which a requester is pending but not granted, saturating.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Register last_srv (I/D).
- Reset (rst=0, asynchronous) forces:
  - state to IDLE and last_srv to D;
  - all counters to 0;
  - pmem_read, pmem_write, i_resp and d_resp to 0.
- Reset mid-transaction abandons the downstream request immediately. No resp is issued for the abandoned request.
- Requesters hold read/write and address/data stable until their resp. Asserting d_read and d_write together is illegal; the bench asserts against it.
- IDLE transitions (one arbitration cycle; pmem_* requests are low in IDLE):
  - Only i_read pending → SERVE_I.
  - Only d_read or d_write pending → SERVE_D.
  - Both pending → serve the requester opposite last_srv. The first tie after reset goes to icache.
- SERVE_I:
  - pmem_read=1, pmem_addr=i_addr, pmem_write=0.
  - On pmem_resp: i_resp=1 in the same cycle (combinational pass-through), i_rdata=pmem_rdata, last_srv←I, i_grants++, next state IDLE.
- SERVE_D:
  - pmem_read=d_read, pmem_write=d_write, pmem_addr=d_addr, pmem_wdata=d_wdata.
  - On pmem_resp: d_resp=1 in the same cycle, d_rdata=pmem_rdata, last_srv←D, d_grants++, next state IDLE.
- pmem_resp arriving in IDLE is ignored.
- The non-granted requester's resp stays 0.
- i_rdata and d_rdata are driven with pmem_rdata at all times. Data is valid only while the matching resp is high.
- Minimum occupancy per transaction: 1 IDLE cycle plus downstream latency.
- Back-to-back transactions always pass through IDLE for one cycle. After its resp, a requester re-requests no earlier than the cycle after resp.
- conflict_cycles increments each cycle in which either of these holds:
  - state≠IDLE and the non-served requester's request is high;
  - state=IDLE and both requesters are pending.
- All counters saturate at 2^CNT_W−1 and do not wrap.

Decomposition:
- Shared package (alongside the existing cache type enums) holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D};
  - arb_src_t enum {SRC_I, SRC_D}.
- The saturating counter is a natural sub-module: sat_counter (inc, clr via reset, CNT_W parameter), instantiated three times.
- Everything else lives in cacheline_arbiter.

Test Plan:
- I-only: i_read=1, i_addr=0x0000_0060; pmem_resp returns line 0xA5..A5 after 4 cycles → pmem_read=1 with pmem_addr=0x60; i_resp pulses for exactly 1 cycle with i_rdata=0xA5..A5; i_grants=1; d_resp stays 0.
- D-writeback: d_write=1, d_addr=0x1000_0020, d_wdata=0x1234..; pmem_resp after 3 cycles → pmem_write=1, pmem_read=0, pmem_wdata matches; d_resp pulses once; d_grants=1.
- Tie after reset: i_read and d_read raised in the same cycle, each resp after 2 cycles → icache is served first, then dcache. Raise both again → icache is served first again, because last_srv=D after the dcache transaction.
- Contention counting: d_read held while SERVE_I lasts 5 cycles → conflict_cycles increases by ≥5; dcache is served next without glitching pmem_addr during SERVE_I.
- Async reset mid-SERVE_D: drive rst=0 between clock edges → pmem_write drops immediately; state is IDLE, counters are 0, and no d_resp is issued. After rst=1, a new request completes normally.
- Saturation: force CNT_W=4 and run 20 icache transactions → i_grants holds at 15.
